// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types for the RV32I pipeline stall/flush sequencer.
// Also supplies a default `XLEN (32) when no project-wide value is defined.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_pipe_ctrl_pkg;

    // Sequencer states; encodings are visible on o_ctrl_state.
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2
    } pctrl_state_e;

    // One bundle of pipeline-register controls.
    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic de_en;
        logic de_flush;
        logic em_en;
        logic mw_en;
    } pctrl_ctl_t;

    // All five enables set to en, both flushes set to flush.
    function automatic pctrl_ctl_t ctl_uniform(input logic en, input logic flush);
        pctrl_ctl_t c;
        c.pc_en    = en;
        c.fd_en    = en;
        c.fd_flush = flush;
        c.de_en    = en;
        c.de_flush = flush;
        c.em_en    = en;
        c.mw_en    = en;
        return c;
    endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_hazard.sv
// Load-use hazard detect: a load in E whose rd feeds rs1/rs2 of the instruction in D.
module riscv_pipe_ctrl_hazard (
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_memread,
    output logic       o_hazard
);

    // x0 never carries a dependency.
    always_comb begin
        o_hazard = i_ex_memread && (i_ex_rd != 5'd0) &&
                   ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: boot hold, branch flush,
// load-use bubble, fetch-miss bubble and data-memory wait with timeout.
// Optional macro RISCV_PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
module riscv_pipe_ctrl
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [4:0]       i_ctrl_id_rs1,
    input  logic [4:0]       i_ctrl_id_rs2,
    input  logic [4:0]       i_ctrl_ex_rd,
    input  logic             i_ctrl_ex_memread,
    input  logic             i_ctrl_ex_br_taken,
    input  logic             i_ctrl_imem_valid,
    input  logic             i_ctrl_mem_req,
    input  logic             i_ctrl_mem_ack,
    output logic             o_ctrl_pc_en,
    output logic             o_ctrl_fd_en,
    output logic             o_ctrl_fd_flush,
    output logic             o_ctrl_de_en,
    output logic             o_ctrl_de_flush,
    output logic             o_ctrl_em_en,
    output logic             o_ctrl_mw_en,
    output logic             o_ctrl_mem_err,
`ifdef RISCV_PIPE_CTRL_PERF_EN
    output logic [`XLEN-1:0] o_ctrl_stall_cnt,
    output logic [`XLEN-1:0] o_ctrl_flush_cnt,
`endif
    output logic [1:0]       o_ctrl_state
);

    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pctrl_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pctrl_ctl_t       ctl;
    logic             mem_err;
    logic             hazard;

    riscv_pipe_ctrl_hazard u_hazard (
        .i_rs1        (i_ctrl_id_rs1),
        .i_rs2        (i_ctrl_id_rs2),
        .i_ex_rd      (i_ctrl_ex_rd),
        .i_ex_memread (i_ctrl_ex_memread),
        .o_hazard     (hazard)
    );

    // State and shared boot/timeout counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and pipeline controls decoded from the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = ctl_uniform(1'b0, 1'b1);
        mem_err = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (i_ctrl_mem_req && !i_ctrl_mem_ack) begin
                    ctl     = ctl_uniform(1'b0, 1'b0);
                    state_d = ST_MEMWAIT;
                end else if (i_ctrl_ex_br_taken) begin
                    ctl = ctl_uniform(1'b1, 1'b1);
                end else if (hazard) begin
                    ctl          = ctl_uniform(1'b1, 1'b0);
                    ctl.pc_en    = 1'b0;
                    ctl.fd_en    = 1'b0;
                    ctl.de_flush = 1'b1;
                end else if (!i_ctrl_imem_valid) begin
                    ctl          = ctl_uniform(1'b1, 1'b0);
                    ctl.pc_en    = 1'b0;
                    ctl.fd_flush = 1'b1;
                end else begin
                    ctl = ctl_uniform(1'b1, 1'b0);
                end
            end
            ST_MEMWAIT: begin
                ctl = ctl_uniform(i_ctrl_mem_ack, 1'b0);
                if (i_ctrl_mem_ack) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    ctl     = ctl_uniform(1'b1, 1'b0);
                    mem_err = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output mapping.
    always_comb begin
        o_ctrl_pc_en    = ctl.pc_en;
        o_ctrl_fd_en    = ctl.fd_en;
        o_ctrl_fd_flush = ctl.fd_flush;
        o_ctrl_de_en    = ctl.de_en;
        o_ctrl_de_flush = ctl.de_flush;
        o_ctrl_em_en    = ctl.em_en;
        o_ctrl_mw_en    = ctl.mw_en;
        o_ctrl_mem_err  = mem_err;
        o_ctrl_state    = state_q;
    end

`ifdef RISCV_PIPE_CTRL_PERF_EN
    logic [`XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [`XLEN-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of stalled-PC cycles and F/D flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_RUN || state_q == ST_MEMWAIT) && !ctl.pc_en && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + `XLEN'(1);
        if ((state_q == ST_RUN) && ctl.fd_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + `XLEN'(1);
    end

    // Performance counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_ctrl_stall_cnt = stall_cnt_q;
    assign o_ctrl_flush_cnt = flush_cnt_q;
`endif

endmodule
